// File: rtl/vga_rect_arbiter.sv
// Round-robin arbiter that shares one VGA pixel-write port between four rectangle-fill clients.
// Optional on-screen clipping of plot is enabled by defining VGA_RECT_ARBITER_CLIP_EN.
module vga_rect_arbiter #(
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int CW      = 3,
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic [3:0]      req,
  input  logic [4*XW-1:0] req_x,
  input  logic [4*YW-1:0] req_y,
  input  logic [4*XW-1:0] req_w,
  input  logic [4*YW-1:0] req_h,
  input  logic [4*CW-1:0] req_colour,
  output logic [3:0]      grant,
  output logic [3:0]      done,
  output logic            busy,
  output logic [XW-1:0]   VGA_X,
  output logic [YW-1:0]   VGA_Y,
  output logic [CW-1:0]   VGA_COLOR,
  output logic            plot
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t        state;
  logic [XW-1:0] x_q, w_q, xc;
  logic [YW-1:0] y_q, h_q, yc;
  logic [CW-1:0] colour_q;
  logic [1:0]    owner, ptr;

  logic [1:0]    sel_idx;
  logic [XW-1:0] sel_w;
  logic [YW-1:0] sel_h;

  // First requester found scanning ptr, ptr+1, ... (mod 4)
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found   = 1'b0;
    sel_idx = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found   = 1'b1;
        sel_idx = idx;
      end
    end
  end

  assign sel_w = req_w[sel_idx*XW +: XW];
  assign sel_h = req_h[sel_idx*YW +: YW];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      grant    <= '0;
      done     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      colour_q <= '0;
      xc       <= '0;
      yc       <= '0;
      owner    <= '0;
      ptr      <= '0;
    end else begin
      grant <= '0;
      done  <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            x_q      <= req_x[sel_idx*XW +: XW];
            y_q      <= req_y[sel_idx*YW +: YW];
            w_q      <= sel_w;
            h_q      <= sel_h;
            colour_q <= req_colour[sel_idx*CW +: CW];
            owner    <= sel_idx;
            grant    <= 4'b0001 << sel_idx;
            xc       <= '0;
            yc       <= '0;
            state    <= (sel_w != '0 && sel_h != '0) ? DRAW : DONE;
          end
        end
        DRAW: begin
          if (xc == w_q - 1'b1) begin
            xc <= '0;
            yc <= yc + 1'b1;
            if (yc == h_q - 1'b1)
              state <= DONE;
          end else begin
            xc <= xc + 1'b1;
          end
        end
        DONE: begin
          done  <= 4'b0001 << owner;
          ptr   <= owner + 2'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef VGA_RECT_ARBITER_CLIP_EN
  localparam logic [XW:0] XLIM = XSCREEN[XW:0];
  localparam logic [YW:0] YLIM = YSCREEN[YW:0];
  logic [XW:0] sum_x;
  logic [YW:0] sum_y;
  // One bit wider so off-screen coordinates do not wrap back on-screen
  assign sum_x = {1'b0, x_q} + {1'b0, xc};
  assign sum_y = {1'b0, y_q} + {1'b0, yc};
  assign plot  = (state == DRAW) && (sum_x < XLIM) && (sum_y < YLIM);
`else
  assign plot  = (state == DRAW);
`endif

  assign VGA_X     = (state == DRAW) ? x_q + xc : '0;
  assign VGA_Y     = (state == DRAW) ? y_q + yc : '0;
  assign VGA_COLOR = (state == DRAW) ? colour_q : '0;

endmodule

// File: tb/tb_vga_rect_arbiter.sv
// Directed self-checking bench for vga_rect_arbiter (default build and VGA_RECT_ARBITER_CLIP_EN build).
module tb_vga_rect_arbiter;
  localparam int XW = 8, YW = 7, CW = 3;

  logic            Clock = 1'b0;
  logic            Resetn;
  logic [3:0]      req;
  logic [4*XW-1:0] req_x, req_w;
  logic [4*YW-1:0] req_y, req_h;
  logic [4*CW-1:0] req_colour;
  logic [3:0]      grant, done;
  logic            busy, plot;
  logic [XW-1:0]   VGA_X;
  logic [YW-1:0]   VGA_Y;
  logic [CW-1:0]   VGA_COLOR;

  int total = 0;
  int bad   = 0;

  vga_rect_arbiter #(.XW(XW), .YW(YW), .CW(CW), .XSCREEN(160), .YSCREEN(120)) dut (
    .Clock(Clock), .Resetn(Resetn), .req(req),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_colour(req_colour),
    .grant(grant), .done(done), .busy(busy),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot(plot)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic set_client(input int i, input int x, input int y, input int w, input int h, input int c);
    req_x[i*XW +: XW]      = XW'(x);
    req_y[i*YW +: YW]      = YW'(y);
    req_w[i*XW +: XW]      = XW'(w);
    req_h[i*YW +: YW]      = YW'(h);
    req_colour[i*CW +: CW] = CW'(c);
  endtask

  task automatic test_reset;
    Resetn = 1'b0;
    req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    tick; tick;
    total++;
    if ({grant, done, busy, plot} !== 10'b0 || VGA_X !== '0 || VGA_Y !== '0 || VGA_COLOR !== '0) begin
      bad++;
      $display("FAIL reset: grant=%b done=%b busy=%b plot=%b x=%0d y=%0d c=%0d required all 0",
               grant, done, busy, plot, VGA_X, VGA_Y, VGA_COLOR);
    end
    Resetn = 1'b1;
    tick;
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_basic;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    logic [3:0]    eg;
    set_client(1, 10, 20, 3, 2, 4);
    req = 4'b0010;
    tick;
    for (int p = 0; p < 6; p++) begin
      ex = XW'(10 + p % 3);
      ey = YW'(20 + p / 3);
      eg = (p == 0) ? 4'b0010 : 4'b0000;
      total++;
      if (plot !== 1'b1 || VGA_X !== ex || VGA_Y !== ey || VGA_COLOR !== 3'd4 || grant !== eg || busy !== 1'b1) begin
        bad++;
        $display("FAIL basic_pixel%0d: plot=%b x=%0d y=%0d c=%0d grant=%b busy=%b required plot=1 x=%0d y=%0d c=4 grant=%b busy=1",
                 p, plot, VGA_X, VGA_Y, VGA_COLOR, grant, busy, ex, ey, eg);
      end
      if (p == 0) req = '0;
      tick;
    end
    total++;
    if (plot !== 1'b0 || done !== 4'b0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_done_state: plot=%b done=%b busy=%b required 0 0000 1", plot, done, busy);
    end
    tick;
    total++;
    if (done !== 4'b0010 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse: done=%b busy=%b required 0010 0", done, busy);
    end
    tick;
    total++;
    if (done !== 4'b0000) begin
      bad++;
      $display("FAIL basic_done_width: done=%b required 0000", done);
    end
    $display("test_basic: 3x2 rectangle from client 1");
  endtask

  task automatic test_contention;
    int         ord [4] = '{0, 2, 0, 2};
    logic [3:0] eg;
    int         c;
    Resetn = 1'b0; tick; Resetn = 1'b1; tick;
    set_client(0, 1, 1, 1, 1, 1);
    set_client(2, 2, 2, 1, 1, 2);
    req = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      eg = 4'(1 << ord[n]);
      c = 0;
      tick;
      while (grant === 4'b0000 && c < 6) begin tick; c++; end
      total++;
      if (grant !== eg) begin
        bad++;
        $display("FAIL contention_grant%0d: grant=%b required %b", n, grant, eg);
      end
      if (n == 3) req = '0;
      tick; tick;
      total++;
      if (done !== eg) begin
        bad++;
        $display("FAIL contention_done%0d: done=%b required %b", n, done, eg);
      end
    end
    $display("test_contention: grant order 0,2,0,2");
  endtask

  task automatic test_rr;
    int c;
    set_client(3, 3, 3, 1, 1, 3);
    set_client(0, 0, 0, 1, 1, 1);
    req = 4'b1000;
    c = 0;
    tick;
    while (grant === 4'b0000 && c < 6) begin tick; c++; end
    total++;
    if (grant !== 4'b1000) begin
      bad++;
      $display("FAIL rr_serve3: grant=%b required 1000", grant);
    end
    req = '0;
    tick; tick;
    req = 4'b1001;
    tick;
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL rr_first: grant=%b required 0001", grant);
    end
    tick; tick; tick;
    total++;
    if (grant !== 4'b1000) begin
      bad++;
      $display("FAIL rr_second: grant=%b required 1000", grant);
    end
    req = '0;
    tick; tick; tick;
    $display("test_rr: client 0 served before client 3 after client 3");
  endtask

  task automatic test_empty;
    set_client(2, 5, 5, 0, 5, 2);
    req = 4'b0100;
    tick;
    total++;
    if (grant !== 4'b0100 || plot !== 1'b0 || busy !== 1'b1 || done !== 4'b0000) begin
      bad++;
      $display("FAIL empty_grant: grant=%b plot=%b busy=%b done=%b required 0100 0 1 0000", grant, plot, busy, done);
    end
    req = '0;
    tick;
    total++;
    if (done !== 4'b0100 || grant !== 4'b0000 || plot !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL empty_done: done=%b grant=%b plot=%b busy=%b required 0100 0000 0 0", done, grant, plot, busy);
    end
    tick;
    $display("test_empty: zero-width rectangle");
  endtask

  task automatic test_edge_x;
    logic [XW-1:0] ex;
    logic          ep;
`ifdef VGA_RECT_ARBITER_CLIP_EN
    int x0 = 158;
`else
    int x0 = 254;
`endif
    set_client(0, x0, 5, 4, 1, 1);
    req = 4'b0001;
    tick;
    for (int p = 0; p < 4; p++) begin
      ex = XW'(x0 + p);
`ifdef VGA_RECT_ARBITER_CLIP_EN
      ep = (p < 2);
`else
      ep = 1'b1;
`endif
      total++;
      if (plot !== ep || VGA_X !== ex) begin
        bad++;
        $display("FAIL edge_x_pixel%0d: plot=%b x=%0d required plot=%b x=%0d", p, plot, VGA_X, ep, ex);
      end
      if (p == 0) req = '0;
      tick;
    end
    tick; tick;
    $display("test_edge_x: rectangle starting at x=%0d", x0);
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    set_client(1, 30, 30, 4, 4, 5);
    req = 4'b0010;
    tick;
    req = '0;
    tick; tick;
    total++;
    if (plot !== 1'b1 || VGA_X !== 8'd32) begin
      bad++;
      $display("FAIL mid_pixel3: plot=%b x=%0d required plot=1 x=32", plot, VGA_X);
    end
    #2 Resetn = 1'b0;
    #1;
    total++;
    if ({grant, done, busy, plot} !== 10'b0 || VGA_X !== '0) begin
      bad++;
      $display("FAIL mid_async: grant=%b done=%b busy=%b plot=%b x=%0d required all 0", grant, done, busy, plot, VGA_X);
    end
    tick; tick;
    Resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done !== 4'b0000 || busy !== 1'b0) dones++;
      tick;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL mid_no_done: %0d active cycles seen required 0", dones);
    end
    set_client(0, 1, 1, 1, 1, 1);
    set_client(3, 3, 3, 1, 1, 3);
    req = 4'b1001;
    tick;
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL mid_priority: grant=%b required 0001", grant);
    end
    req = '0;
    tick; tick;
    total++;
    if (done !== 4'b0001) begin
      bad++;
      $display("FAIL mid_after_done: done=%b required 0001", done);
    end
    $display("test_reset_mid: reset aborts draw, priority restarts at client 0");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_contention;
    test_rr;
    test_empty;
    test_edge_x;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete required finish");
    $fatal(1);
  end
endmodule
